button_bounce_generator: RTL
============================

BUTTON_BOUNCE_GENERATOR -- requirements
Module: button_bounce_generator

Interface
REQ-001 Parameter CLOCK_PERIOD_NS, default 20: clock period in ns.
REQ-002 Parameter BOUNCE_TOGGLES, default 5: level toggles per bounce phase; SHALL be odd and at least 1 (elaboration error otherwise).
REQ-003 Parameter BOUNCE_MASK, default 16'h3FFF: mask applied to the LFSR to form the toggle interval; SHALL be 2^k-1.
REQ-004 Parameter SETTLE_NS, default 2_000_000: stable-release time before completion.
REQ-005 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; SHALL be nonzero.
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 reset_i  input  1  synchronous, active-high reset.
REQ-008 press_valid_i  input  1  request to emulate one button press.
REQ-009 hold_cycles_i  input  32  stable-pressed duration in clocks; sampled on acceptance.
REQ-010 press_ready_o  output  1  high only in IDLE.
REQ-011 button_o  output  1  emulated raw contact level, registered, 1 = pressed; feeds the debounce filter input.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle pulse on completion of a press.

Function
REQ-014 FSM states: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, SETTLE.
REQ-015 Acceptance occurs when press_valid_i and press_ready_o are both high at a clock edge; press_valid_i outside IDLE SHALL be ignored, not queued.
REQ-016 On acceptance at edge T: hold value latched (0 treated as 1), state becomes PRESS_BOUNCE, and button_o toggles to 1 at the same edge T.
REQ-017 Toggle interval = (lfsr & BOUNCE_MASK) + 1 clocks; the LFSR advances exactly once per toggle, and each toggle loads the next interval.
REQ-018 In each bounce phase button_o SHALL toggle exactly BOUNCE_TOGGLES times, the first at phase entry; PRESS_BOUNCE ends at level 1, RELEASE_BOUNCE at level 0.
REQ-019 After the last press toggle's interval expires: HOLD, button_o held at 1 for exactly the latched hold cycles, then RELEASE_BOUNCE, whose first toggle is to 0.
REQ-020 After the last release toggle's interval expires: SETTLE, button_o held at 0 for SETTLE_CYCLES = SETTLE_NS/CLOCK_PERIOD_NS (minimum 1) clocks.
REQ-021 At SETTLE end: done_o high for one cycle, state IDLE, press_ready_o high in the same cycle.
REQ-022 The LFSR is 16-bit Fibonacci, taps 16,14,13,11, shift-left, and is never reset except by reset_i, so successive presses use a continuing sequence.
REQ-023 Counters: 32-bit down-counters, with no wrap-around; expiry is defined as the count reaching 1 at a clock edge.

Reset
REQ-024 With reset_i high at an edge: state IDLE, button_o 0, done_o 0, busy_o 0, press_ready_o 1 after the edge, lfsr = LFSR_SEED, counters 0.
REQ-025 Reset asserted mid-press SHALL abort the press at that edge, with no done_o pulse.

Structure
REQ-026 Shared package button_emu_pkg SHALL hold the state enum, LFSR taps, and an ns-to-cycles constant function.
REQ-027 The LFSR SHALL be the sub-module lfsr16 (ports clk_i, reset_i, step_i, value_o), reusable elsewhere in the test environment.

Verification
REQ-028 Reset then idle -> button_o=0, press_ready_o=1, busy_o=0, no done_o.
REQ-029 BOUNCE_MASK=3, BOUNCE_TOGGLES=5, SETTLE_NS=100, hold=50 -> exactly 5 rising+falling-edge toggles ending at 1, 50 clocks stable at 1, 5 toggles ending at 0, 5 clocks at 0, one done_o; intervals match a reference LFSR model.
REQ-030 hold_cycles_i=0 -> HOLD lasts 1 clock.
REQ-031 press_valid_i held high continuously -> back-to-back presses, with the second accepted in the done_o cycle and the LFSR sequence continuing.
REQ-032 reset_i pulsed during HOLD -> button_o=0 at the next edge, IDLE, no done_o; a subsequent press replays the seed sequence.
REQ-033 Drive button_o into the debounce filter (filter time above 4 x max interval) -> exactly one filtered press pulse per emulated press.

Source files
------------

// File: rtl/button_emu_pkg.sv
// ============================================================================
// Module : button_emu_pkg
// Brief  : Shared types and helpers for the button emulation environment.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESS_BOUNCE   = 3'd1,
        ST_HOLD           = 3'd2,
        ST_RELEASE_BOUNCE = 3'd3,
        ST_SETTLE         = 3'd4
    } state_t;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                                 input int unsigned period_ns);
        int unsigned cycles;
        cycles = ns / period_ns;
        return (cycles == 0) ? 32'd1 : cycles;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// Module : lfsr16
// Brief  : 16-bit shift-left Fibonacci LFSR that advances once per step_i.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import button_emu_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] r_value;
    logic        w_feedback;

    assign w_feedback = ^(r_value & LFSR_TAPS);
    assign value_o    = r_value;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_value <= SEED;
        end else if (step_i) begin
            r_value <= {r_value[14:0], w_feedback};
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_bounce_generator.sv
// ============================================================================
// Module : button_bounce_generator
// Brief  : Emulates a bouncing mechanical push button: press bounce, hold,
//          release bounce and settle, with LFSR-randomised toggle intervals.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_bounce_generator
    import button_emu_pkg::*;
#(
    parameter int unsigned CLOCK_PERIOD_NS = 20,
    parameter int unsigned BOUNCE_TOGGLES  = 5,
    parameter logic [15:0] BOUNCE_MASK     = 16'h3FFF,
    parameter int unsigned SETTLE_NS       = 2_000_000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        press_valid_i,
    input  logic [31:0] hold_cycles_i,
    output logic        press_ready_o,
    output logic        button_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [31:0] c_toggles       = 32'(BOUNCE_TOGGLES);
    localparam logic [31:0] c_settle_cycles = 32'(ns_to_cycles(SETTLE_NS, CLOCK_PERIOD_NS));

    if ((BOUNCE_TOGGLES < 1) || ((BOUNCE_TOGGLES % 2) == 0)) begin : g_bad_toggles
        $error("BOUNCE_TOGGLES must be odd and at least 1");
    end
    if ((BOUNCE_MASK & 16'(BOUNCE_MASK + 16'd1)) != 16'd0) begin : g_bad_mask
        $error("BOUNCE_MASK must be of the form 2^k-1");
    end
    if (LFSR_SEED == 16'd0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    state_t      r_state, w_state_n;
    logic [31:0] r_cnt, w_cnt_n;
    logic [31:0] r_toggles, w_toggles_n;
    logic [31:0] r_hold, w_hold_n;
    logic        r_button, w_button_n;
    logic        r_done, w_done_n;
    logic        w_step;
    logic [15:0] w_lfsr;
    logic [31:0] w_interval;
    logic        w_expired;
    logic [31:0] w_cnt_dec;

    lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .step_i  (w_step),
        .value_o (w_lfsr)
    );

    assign w_interval = {16'd0, (w_lfsr & BOUNCE_MASK)} + 32'd1;
    assign w_expired  = (r_cnt == 32'd1);
    // Saturating decrement: the counter never wraps below zero.
    assign w_cnt_dec  = (r_cnt == 32'd0) ? 32'd0 : (r_cnt - 32'd1);

    assign press_ready_o = (r_state == ST_IDLE);
    assign busy_o        = (r_state != ST_IDLE);
    assign button_o      = r_button;
    assign done_o        = r_done;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 32'd0;
            r_toggles <= 32'd0;
            r_hold    <= 32'd0;
            r_button  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_toggles <= w_toggles_n;
            r_hold    <= w_hold_n;
            r_button  <= w_button_n;
            r_done    <= w_done_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_toggles_n = r_toggles;
        w_hold_n    = r_hold;
        w_button_n  = r_button;
        w_done_n    = 1'b0;
        w_step      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (press_valid_i) begin
                    w_hold_n    = (hold_cycles_i == 32'd0) ? 32'd1 : hold_cycles_i;
                    w_state_n   = ST_PRESS_BOUNCE;
                    w_button_n  = 1'b1;
                    w_cnt_n     = w_interval;
                    w_toggles_n = 32'd1;
                    w_step      = 1'b1;
                end
            end
            ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
                if (!w_expired) begin
                    w_cnt_n = w_cnt_dec;
                end else if (r_toggles == c_toggles) begin
                    // Last toggle of the phase has lived out its interval.
                    w_state_n = (r_state == ST_PRESS_BOUNCE) ? ST_HOLD : ST_SETTLE;
                    w_cnt_n   = (r_state == ST_PRESS_BOUNCE) ? r_hold : c_settle_cycles;
                end else begin
                    w_button_n  = ~r_button;
                    w_cnt_n     = w_interval;
                    w_toggles_n = r_toggles + 32'd1;
                    w_step      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_expired) begin
                    w_state_n   = ST_RELEASE_BOUNCE;
                    w_button_n  = 1'b0;
                    w_cnt_n     = w_interval;
                    w_toggles_n = 32'd1;
                    w_step      = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            ST_SETTLE: begin
                if (w_expired) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = 32'd0;
                    w_done_n  = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_cnt_n   = 32'd0;
            end
        endcase
    end

endmodule

`default_nettype wire
